// File: rtl/cmd_dispatch.sv
// cmd_dispatch: owns the shared UART. Reads one command byte in IDLE,
// dispatches it to one of N_HANDLERS handlers through an activate/done
// session, routes the selected handler's transmit requests to the UART
// transmitter, answers unknown commands with a single NAK byte and aborts
// handlers that overstay the optional watchdog limit.
module cmd_dispatch #(
  parameter int unsigned N_HANDLERS     = 4,
  parameter logic [7:0]  CMD_BASE       = 8'h01,
  parameter logic [7:0]  NAK_BYTE       = 8'hEE,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rx_ready,
  input  logic [7:0]              rx_data,
  input  logic                    tx_active,
  output logic [7:0]              tx_data,
  output logic                    tx_start,
  output logic [N_HANDLERS-1:0]   h_activate,
  input  logic [N_HANDLERS-1:0]   h_done,
  input  logic [8*N_HANDLERS-1:0] h_tx_data,
  input  logic [N_HANDLERS-1:0]   h_tx_start,
  output logic                    busy,
  output logic [3:0]              sel,
  output logic                    err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DECODE    = 3'd1,
    S_RUN       = 3'd2,
    S_RELEASE   = 3'd3,
    S_NAK_WAIT  = 3'd4,
    S_NAK_SEND  = 3'd5,
    S_NAK_DRAIN = 3'd6
  } state_t;

  localparam logic [7:0]  N_H8    = 8'(N_HANDLERS);
  // Last counter value before the watchdog fires; only used when enabled.
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;
  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);

  state_t                  state_q, state_d;
  logic [7:0]              cmd_q, cmd_d;
  logic [3:0]              sel_q, sel_d;
  logic [N_HANDLERS-1:0]   act_q, act_d;
  logic                    err_q, err_d;
  logic [31:0]             cnt_q, cnt_d;

  logic [7:0]              idx_s;
  logic [N_HANDLERS-1:0]   dec_s;
  logic                    sel_done_s;
  logic                    sel_start_s;
  logic [7:0]              sel_data_s;
  logic                    tx_start_s;
  logic [7:0]              tx_data_s;

  // Command-to-handler index (8-bit wrap, so bytes below CMD_BASE land out of range) and its one-hot form.
  always_comb begin
    idx_s = cmd_q - CMD_BASE;
    dec_s = '0;
    for (int k = 0; k < N_HANDLERS; k++) begin
      dec_s[k] = (idx_s == 8'(k));
    end
  end

  // AND-OR mux picking the selected handler's done/start/data; other handlers are ignored.
  always_comb begin
    sel_done_s  = 1'b0;
    sel_start_s = 1'b0;
    sel_data_s  = 8'h00;
    for (int k = 0; k < N_HANDLERS; k++) begin
      sel_done_s  = sel_done_s  | (h_done[k]     & (sel_q == 4'(k)));
      sel_start_s = sel_start_s | (h_tx_start[k] & (sel_q == 4'(k)));
      sel_data_s  = sel_data_s  | (h_tx_data[8*k +: 8] & {8{sel_q == 4'(k)}});
    end
  end

  // Next-state logic for the dispatcher session plus the transmitter routing.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    sel_d      = sel_q;
    act_d      = act_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    tx_start_s = 1'b0;
    tx_data_s  = 8'h00;
    case (state_q)
      S_IDLE: begin
        if (rx_ready) begin
          cmd_d   = rx_data;
          err_d   = 1'b0;
          state_d = S_DECODE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DECODE: begin
        if (idx_s < N_H8) begin
          sel_d   = idx_s[3:0];
          act_d   = dec_s;
          cnt_d   = 32'd0;
          state_d = S_RUN;
        end else begin
          state_d = S_NAK_WAIT;
        end
      end
      S_RUN: begin
        tx_start_s = sel_start_s;
        tx_data_s  = sel_data_s;
        if (sel_done_s) begin
          // Done has priority over a coincident watchdog expiry.
          act_d   = '0;
          state_d = S_RELEASE;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          act_d   = '0;
          err_d   = 1'b1;
          state_d = S_RELEASE;
        end else if (cnt_q != 32'hFFFF_FFFF) begin
          cnt_d = cnt_q + 32'd1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_RELEASE: begin
        if (!sel_done_s && !rx_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RELEASE;
        end
      end
      S_NAK_WAIT: begin
        if (!tx_active) begin
          state_d = S_NAK_SEND;
        end else begin
          state_d = S_NAK_WAIT;
        end
      end
      S_NAK_SEND: begin
        tx_start_s = 1'b1;
        tx_data_s  = NAK_BYTE;
        state_d    = S_NAK_DRAIN;
      end
      S_NAK_DRAIN: begin
        if (!rx_ready && !tx_active) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_NAK_DRAIN;
        end
      end
      default: begin
        act_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and session registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cmd_q   <= 8'h00;
      sel_q   <= 4'd0;
      act_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      sel_q   <= sel_d;
      act_q   <= act_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign tx_start    = tx_start_s;
  assign tx_data     = tx_data_s;
  assign h_activate  = act_q;
  assign sel         = sel_q;
  assign err_timeout = err_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_cmd_dispatch.sv
// Testbench for cmd_dispatch: a scoreboard queue of expected transmit bytes
// is filled as stimulus is driven and drained by a monitor on tx_start.
module tb_cmd_dispatch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_active = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic [3:0]  h_activate;
  logic [3:0]  h_done = 4'h0;
  logic [31:0] h_tx_data = 32'h0;
  logic [3:0]  h_tx_start = 4'h0;
  logic        busy;
  logic [3:0]  sel;
  logic        err_timeout;

  int          n_checks = 0;
  int          n_pass = 0;
  int          n_seen = 0;
  int          n_exp = 0;
  logic [7:0]  exp_q[$];

  cmd_dispatch #(
    .N_HANDLERS(4), .CMD_BASE(8'h01), .NAK_BYTE(8'hEE), .TIMEOUT_CYCLES(20)
  ) dut (
    .clk(clk), .reset(reset), .rx_ready(rx_ready), .rx_data(rx_data),
    .tx_active(tx_active), .tx_data(tx_data), .tx_start(tx_start),
    .h_activate(h_activate), .h_done(h_done), .h_tx_data(h_tx_data),
    .h_tx_start(h_tx_start), .busy(busy), .sel(sel), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every tx_start must match the next expected byte.
  always @(negedge clk) begin
    if (tx_start === 1'b1) begin
      n_seen++;
      if (exp_q.size() == 0) begin
        check_eq("tx_unexpected_start", 32'(tx_start), 32'd0);
      end else begin
        check_eq("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // Issue a valid command; rx_ready held for 3 sampled edges; returns 1ns after the third edge.
  task automatic start_cmd(input logic [7:0] c, input int k);
    logic [3:0] oh;
    oh = 4'b0001 << k;
    rx_data  = c;
    rx_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    check_eq("accept_busy", 32'(busy), 32'd1);
    check_eq("accept_noact", 32'(h_activate), 32'd0);
    check_eq("accept_err_clr", 32'(err_timeout), 32'd0);
    @(posedge clk); @(negedge clk);
    check_eq("run_act", 32'(h_activate), 32'(oh));
    check_eq("run_sel", 32'(sel), 32'(k));
    @(posedge clk); #1;
    rx_ready = 1'b0;
  endtask

  // Handler k transmits one byte for one cycle; routed bytes go into the scoreboard.
  task automatic h_send(input int k, input logic [7:0] b, input bit routed);
    h_tx_data[8*k +: 8] = b;
    h_tx_start[k] = 1'b1;
    if (routed) begin
      exp_q.push_back(b);
      n_exp++;
    end
    @(posedge clk); #1;
    h_tx_start[k] = 1'b0;
    @(posedge clk); #1;
  endtask

  // Handler k signals done; activate must drop on that edge and IDLE follow one edge later.
  task automatic h_finish(input int k);
    h_done[k] = 1'b1;
    @(posedge clk); @(negedge clk);
    check_eq("done_act_low", 32'(h_activate), 32'd0);
    check_eq("release_busy", 32'(busy), 32'd1);
    h_done[k] = 1'b0;
    @(posedge clk); @(negedge clk);
    check_eq("idle_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_act", 32'(h_activate), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_sel", 32'(sel), 32'd0);
    check_eq("rst_err", 32'(err_timeout), 32'd0);
    check_eq("rst_txs", 32'(tx_start), 32'd0);
    check_eq("rst_txd", 32'(tx_data), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Valid command to handler 0 with three bytes
    start_cmd(8'h01, 0);
    h_send(0, 8'hA1, 1'b1);
    h_send(0, 8'hB2, 1'b1);
    h_send(0, 8'hC3, 1'b1);
    check_eq("t1_tx_count", 32'(n_seen), 32'd3);
    h_finish(0);

    // Unknown command, transmitter busy for 5 sampled cycles
    tx_active = 1'b1;
    rx_data   = 8'h40;
    rx_ready  = 1'b1;
    @(posedge clk); @(negedge clk);
    check_eq("nak_busy", 32'(busy), 32'd1);
    @(posedge clk); @(negedge clk);
    check_eq("nak_noact", 32'(h_activate), 32'd0);
    check_eq("nak_wait_txs", 32'(tx_start), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    tx_active = 1'b0;
    rx_ready  = 1'b0;
    exp_q.push_back(8'hEE);
    n_exp++;
    @(negedge clk);
    check_eq("nak_not_early", 32'(tx_start), 32'd0);
    @(posedge clk); @(negedge clk);
    check_eq("nak_start", 32'(tx_start), 32'd1);
    check_eq("nak_data", 32'(tx_data), 32'hEE);
    @(posedge clk); @(negedge clk);
    check_eq("nak_single", 32'(tx_start), 32'd0);
    check_eq("nak_drain_busy", 32'(busy), 32'd1);
    @(posedge clk); @(negedge clk);
    check_eq("nak_idle", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // Wrapped index: 8'h00 - 8'h01 = 8'hFF is out of range
    rx_data  = 8'h00;
    rx_ready = 1'b1;
    exp_q.push_back(8'hEE);
    n_exp++;
    @(posedge clk); #1;
    rx_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    check_eq("wrap_noact", 32'(h_activate), 32'd0);
    check_eq("wrap_wait_txs", 32'(tx_start), 32'd0);
    @(posedge clk); @(negedge clk);
    check_eq("wrap_nak", 32'(tx_start), 32'd1);
    @(posedge clk);
    @(posedge clk); @(negedge clk);
    check_eq("wrap_idle", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // Watchdog: handler 2 never finishes; activate rose at edge P2, must fall at P22
    start_cmd(8'h03, 2);
    repeat (18) @(posedge clk);
    @(negedge clk);
    check_eq("wd_hold", 32'(h_activate), 32'h4);
    check_eq("wd_err_pre", 32'(err_timeout), 32'd0);
    @(posedge clk); @(negedge clk);
    check_eq("wd_drop", 32'(h_activate), 32'd0);
    check_eq("wd_err_set", 32'(err_timeout), 32'd1);
    @(posedge clk); @(negedge clk);
    check_eq("wd_idle", 32'(busy), 32'd0);
    check_eq("wd_err_sticky", 32'(err_timeout), 32'd1);
    @(posedge clk); #1;

    // Isolation: handler 1 session while handler 3 toggles start and done
    start_cmd(8'h02, 1);
    h_done[3] = 1'b1;
    h_send(3, 8'hCC, 1'b0);
    h_done[3] = 1'b0;
    check_eq("iso_act", 32'(h_activate), 32'h2);
    check_eq("iso_busy", 32'(busy), 32'd1);
    h_send(1, 8'h5A, 1'b1);
    h_tx_start[3] = 1'b1;
    h_done[3] = 1'b1;
    h_send(1, 8'h33, 1'b1);
    h_tx_start[3] = 1'b0;
    h_done[3] = 1'b0;
    check_eq("iso_act2", 32'(h_activate), 32'h2);
    h_finish(1);

    // Reset mid-RUN, then a normal dispatch
    start_cmd(8'h04, 3);
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    check_eq("mrst_act", 32'(h_activate), 32'd0);
    check_eq("mrst_busy", 32'(busy), 32'd0);
    check_eq("mrst_sel", 32'(sel), 32'd0);
    check_eq("mrst_txs", 32'(tx_start), 32'd0);
    check_eq("mrst_txd", 32'(tx_data), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    start_cmd(8'h01, 0);
    h_send(0, 8'h77, 1'b1);
    h_finish(0);

    repeat (3) @(posedge clk);
    #1;
    check_eq("tx_count", 32'(n_seen), 32'(n_exp));
    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cmd_dispatch.md
# cmd_dispatch

Command dispatcher that owns the shared UART for the oscilloscope firmware. In idle it reads one command byte from the UART receiver and decodes it to one of N command handlers (e.g. the counter-reply handler). It hands that handler an activate/done session and routes its transmit requests onto the single UART transmitter. Unknown commands get a one-byte NAK, and a watchdog aborts handlers that hang.

## Interface
Parameters:
- N_HANDLERS, 4, number of attached handlers (1..16)
- CMD_BASE, 8'h01, command byte mapped to handler 0; byte CMD_BASE+k maps to handler k
- NAK_BYTE, 8'hEE, byte transmitted for an unknown command
- TIMEOUT_CYCLES, 0, watchdog limit in clk cycles spent in RUN; 0 disables the watchdog

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low
- rx_ready  in  1  UART receive byte valid (level, held while byte present)
- rx_data  in  8  UART received byte
- tx_active  in  1  UART transmitter busy
- tx_data  out  8  byte to UART transmitter
- tx_start  out  1  UART transmit request
- h_activate  out  N_HANDLERS  one-hot activate to handlers (registered)
- h_done  in  N_HANDLERS  handler done flags
- h_tx_data  in  8*N_HANDLERS  handler k byte at [8k+7:8k]
- h_tx_start  in  N_HANDLERS  handler transmit requests
- busy  out  1  high whenever state is not IDLE
- sel  out  4  index of the current/last selected handler
- err_timeout  out  1  sticky; set on watchdog abort, cleared when the next command is accepted

## Operation
- States: IDLE, DECODE, RUN, RELEASE, NAK_WAIT, NAK_SEND, NAK_DRAIN.
- IDLE: on rx_ready=1, latch rx_data into cmd, clear err_timeout, go to DECODE.
- DECODE: idx = cmd - CMD_BASE, computed as 8-bit unsigned with wrap. A wrapped value is out of range.
  - If idx < N_HANDLERS: sel<=idx, h_activate<=1<<idx, clear the watchdog counter, go to RUN.
  - Otherwise go to NAK_WAIT.
- RUN: tx_data = h_tx_data[sel] and tx_start = h_tx_start[sel], combinational passthrough.
  - If h_done[sel]=1: h_activate<=0, go to RELEASE.
  - Else if TIMEOUT_CYCLES≠0 and the counter has reached TIMEOUT_CYCLES-1: h_activate<=0, err_timeout<=1, go to RELEASE.
  - Otherwise the counter increments (32-bit, saturating).
- RELEASE: wait for h_done[sel]=0 and rx_ready=0, then go to IDLE. tx_start is forced 0.
- NAK_WAIT: when tx_active=0, go to NAK_SEND.
- NAK_SEND: tx_data=NAK_BYTE and tx_start=1 for exactly one cycle, then go to NAK_DRAIN.
- NAK_DRAIN: wait for rx_ready=0 and tx_active=0, then go to IDLE.
- Outside RUN and NAK_SEND: tx_start=0 and tx_data=0.
- h_done and h_tx_start from non-selected handlers are ignored. rx_ready is ignored during RUN; the handler consumes it.

## Timing
- Reset (reset=0 at a clk edge) forces state IDLE, h_activate=0, sel=0, err_timeout=0, busy=0, tx_start=0, tx_data=0, counter=0. This applies from any state, including mid-RUN: activate drops and no NAK is sent.
- rx_ready sampled high at edge T:
  - busy=1 after T.
  - h_activate high after T+1.
  - First routed tx_start can appear in the same cycle the handler raises it.
- h_done sampled at edge D: h_activate low after D.
- Minimum RELEASE→IDLE: 1 cycle once the conditions hold. A new command is accepted no earlier than the edge after IDLE is re-entered.
- Watchdog with TIMEOUT_CYCLES=T: activate drops exactly T cycles after RUN entry.
- If h_done and the timeout condition occur in the same cycle, done wins and err_timeout stays 0.
- NAK tx_start is asserted 1 cycle after tx_active is first seen low in NAK_WAIT.

## Test plan
- Valid command: rx_data=8'h01 with rx_ready pulsed 3 cycles, then handler 0 sends 3 bytes and raises done. Required: h_activate=4'b0001 two cycles after rx_ready; exactly 3 tx_start pulses with handler 0's bytes; activate drops 1 cycle after done; busy returns to 0.
- Unknown command: rx_data=8'h40 with tx_active=1 for 5 cycles. Required: no h_activate; a single tx_start with tx_data=8'hEE in the cycle after tx_active falls; then IDLE.
- Wrap case: rx_data=8'h00 with CMD_BASE=8'h01. Required: treated as unknown and NAK sent.
- Watchdog: TIMEOUT_CYCLES=20 and handler 2 never raises done. Required: h_activate[2] low exactly 20 cycles after rising and err_timeout=1. The next command clears err_timeout.
- Isolation: during a handler 1 session, handler 3 toggles h_tx_start and h_done. Required: tx_start follows handler 1 only.
- Reset mid-RUN, then reset release with a new command. Required: all outputs 0 on the next edge after reset, and a normal dispatch follows.
